// File: rtl/if_pkg.sv
// Shared constants and types for the prefetching instruction-fetch stage.
package if_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned PC_INC       = 4;
    localparam logic [31:0] NOP          = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [XLEN_DEFAULT-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; used both for fetched entries and for the request-PC tag queue.
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (pop_i)  rd_q <= rd_q + 1'b1;
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    // Storage needs no reset: count_q gates every read.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

    assert property (@(posedge clk) disable iff (rst) !(push_i && full_o && !pop_i && !flush_i));
    assert property (@(posedge clk) disable iff (rst) !(pop_i && empty_o && !flush_i));

endmodule

// File: rtl/if_stage_prefetch.sv
// Fetch stage: PC generation, redirect, freeze, decoupled imem request/response with prefetch FIFO.
module if_stage_prefetch
    import if_pkg::*;
#(
    parameter int unsigned     XLEN     = XLEN_DEFAULT,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] PC_RESET = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_address,
    input  logic            freeze,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] instruction
);

    localparam int unsigned    CW         = $clog2(DEPTH) + 1;
    localparam logic [CW:0]    SLOT_LIMIT = (CW+1)'(DEPTH);

    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]     outstanding_q, outstanding_d;
    logic [CW-1:0]     drop_q, drop_d;
    logic              valid_q;
    logic [XLEN-1:0]   pc_q, instr_q;

    logic              req_fire, rsp_keep, rsp_drop, dpush, dpop;
    logic [2*XLEN-1:0] dhead;
    logic [CW-1:0]     dcount, tcount;
    logic              dfull, dempty, tfull, tempty;
    logic [XLEN-1:0]   thead;

    // A slot is reserved at request time, so a kept response always finds room.
    always_comb begin
        imem_req_valid = !branch_taken && (({1'b0, dcount} + {1'b0, outstanding_q}) < SLOT_LIMIT);
        imem_req_addr  = fetch_pc_q;
        req_fire       = imem_req_valid && imem_req_ready;
        rsp_drop       = imem_rsp_valid && (drop_q != '0);
        rsp_keep       = imem_rsp_valid && (drop_q == '0);
        dpush          = rsp_keep && !branch_taken;
        dpop           = !branch_taken && !freeze && !dempty;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (branch_taken)  fetch_pc_d = branch_address & ~XLEN'(3);
        else if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(PC_INC);

        outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);

        // On redirect every request still unanswered after this cycle's beat becomes stale.
        if (branch_taken) drop_d = outstanding_q - CW'(imem_rsp_valid);
        else              drop_d = drop_q - CW'(rsp_drop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= PC_RESET;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= XLEN'(NOP);
        end else if (branch_taken) begin
            valid_q <= 1'b0;
        end else if (!freeze) begin
            if (!dempty) begin
                valid_q <= 1'b1;
                pc_q    <= dhead[2*XLEN-1:XLEN] + XLEN'(PC_INC);
                instr_q <= dhead[XLEN-1:0];
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    assign valid       = valid_q;
    assign pc          = pc_q;
    assign instruction = instr_q;

    fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_data_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (dpush),
        .data_i  ({thead, imem_rsp_data}),
        .pop_i   (dpop),
        .flush_i (branch_taken),
        .data_o  (dhead),
        .count_o (dcount),
        .full_o  (dfull),
        .empty_o (dempty)
    );

    fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (req_fire),
        .data_i  (fetch_pc_q),
        .pop_i   (rsp_keep && !branch_taken),
        .flush_i (branch_taken),
        .data_o  (thead),
        .count_o (tcount),
        .full_o  (tfull),
        .empty_o (tempty)
    );

    assert property (@(posedge clk) disable iff (rst) dpush |-> !dfull);
    assert property (@(posedge clk) disable iff (rst) rsp_keep |-> !tempty);
    assert property (@(posedge clk) disable iff (rst) req_fire |-> !tfull);
    assert property (@(posedge clk) disable iff (rst) (tcount + drop_q) == outstanding_q);

endmodule
